// File: rtl/nios_simple_descriptor_ram_dp.sv
// Dual-port descriptor RAM: two Avalon-MM slaves with pipelined reads and byte writes,
// selectable read-during-write behaviour and a sticky same-address write-collision flag.
module nios_simple_descriptor_ram_dp #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 14,
  parameter int    READ_LATENCY = 1,
  parameter string RDW_MODE     = "OLD_DATA",
  parameter string INIT_FILE    = "nios_simple_descriptor_mem.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    collision,
  input  logic                    collision_clear
);

  localparam int BE         = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam bit P_NEW_DATA = (RDW_MODE == "NEW_DATA");

  // Reject configurations the datapath cannot honour; the memory image must also be named.
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH == 0 ||
      (READ_LATENCY != 1 && READ_LATENCY != 2) ||
      (RDW_MODE != "OLD_DATA" && RDW_MODE != "NEW_DATA") ||
      INIT_FILE == "") begin : g_bad_cfg
    $error("nios_simple_descriptor_ram_dp: unsupported parameter combination");
  end

  logic                  w_en;
  logic                  w_wr1;
  logic                  w_wr2;
  logic                  w_coll_set;
  logic [1:0]            w_rd;
  logic [DATA_WIDTH-1:0] w_word [2];

  logic [DATA_WIDTH-1:0] r_mem   [DEPTH];
  logic                  r_vld   [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_dat   [2][READ_LATENCY];
  logic                  r_rdv   [2];
  logic [DATA_WIDTH-1:0] r_rdata [2];
  logic                  r_coll;

  assign w_en  = clken & ~reset_req;
  assign w_wr1 = w_en & reset_n & s1_chipselect & s1_write;
  assign w_wr2 = w_en & reset_n & s2_chipselect & s2_write;
  assign w_rd  = {w_en & s2_chipselect & s2_read & ~s2_write,
                  w_en & s1_chipselect & s1_read & ~s1_write};

  assign w_coll_set = w_wr1 & w_wr2 & (s1_address == s2_address) &
                      (|(s1_byteenable & s2_byteenable));

  // Word as it will look after this edge's writes; s1 owns bytes both ports enable.
  function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                    input logic [ADDR_WIDTH-1:0] addr);
    f_merge = old_word;
    for (int b = 0; b < BE; b++) begin
      if (w_wr1 && s1_address == addr && s1_byteenable[b])
        f_merge[b*8 +: 8] = s1_writedata[b*8 +: 8];
      else if (w_wr2 && s2_address == addr && s2_byteenable[b])
        f_merge[b*8 +: 8] = s2_writedata[b*8 +: 8];
    end
  endfunction

  always_comb begin
    w_word[0] = r_mem[s1_address];
    w_word[1] = r_mem[s2_address];
    if (P_NEW_DATA) begin
      w_word[0] = f_merge(r_mem[s1_address], s1_address);
      w_word[1] = f_merge(r_mem[s2_address], s2_address);
    end
  end

  // NOTE: the storage array has no reset branch; its contents survive reset_n and
  // only the write enables (which include reset_n) protect it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE; b++) begin
      if (w_wr2 && s2_byteenable[b]) r_mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      if (w_wr1 && s1_byteenable[b]) r_mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        r_rdv[p]   <= 1'b0;
        r_rdata[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) begin
          r_vld[p][s] <= 1'b0;
          r_dat[p][s] <= '0;
        end
      end
    end else if (w_en) begin
      for (int p = 0; p < 2; p++) begin
        r_vld[p][0] <= w_rd[p];
        if (w_rd[p]) r_dat[p][0] <= w_word[p];
        for (int s = 1; s < READ_LATENCY; s++) begin
          r_vld[p][s] <= r_vld[p][s-1];
          r_dat[p][s] <= r_dat[p][s-1];
        end
        r_rdv[p] <= r_vld[p][READ_LATENCY-1];
        if (r_vld[p][READ_LATENCY-1]) r_rdata[p] <= r_dat[p][READ_LATENCY-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_coll <= 1'b0;
    else if (w_en) begin
      if (w_coll_set)           r_coll <= 1'b1;
      else if (collision_clear) r_coll <= 1'b0;
    end
  end

  // Valid is masked while frozen so a held pulse is seen exactly once, after resume.
  assign s1_readdatavalid = r_rdv[0] & w_en;
  assign s2_readdatavalid = r_rdv[1] & w_en;
  assign s1_readdata      = r_rdata[0];
  assign s2_readdata      = r_rdata[1];
  assign collision        = r_coll;

endmodule

// File: tb/tb_nios_simple_descriptor_ram_dp.sv
// Bench for nios_simple_descriptor_ram_dp: instance A (latency 1, OLD_DATA) and instance B
// (latency 2, NEW_DATA) share stimulus; a scoreboard queue per instance/port checks reads.
module tb_nios_simple_descriptor_ram_dp;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] e_old;
    logic [31:0] e_new;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n, reset_req, clken, collision_clear;
  logic [13:0] s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] w_rdata [4];
  logic        w_rdv   [4];
  logic        w_coll  [2];

  exp_t q [4][$];
  exp_t e;
  int   pushed [4];
  int   got    [4];
  int   en_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  req_t NOP = '{default: '0};

  always #5 clk = ~clk;

  nios_simple_descriptor_ram_dp #(.READ_LATENCY(1), .RDW_MODE("OLD_DATA")) u_dut_a (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(w_rdata[0]), .s1_readdatavalid(w_rdv[0]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(w_rdata[1]), .s2_readdatavalid(w_rdv[1]),
    .collision(w_coll[0]), .collision_clear(collision_clear));

  nios_simple_descriptor_ram_dp #(.READ_LATENCY(2), .RDW_MODE("NEW_DATA")) u_dut_b (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(w_rdata[2]), .s1_readdatavalid(w_rdv[2]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(w_rdata[3]), .s2_readdatavalid(w_rdv[3]),
    .collision(w_coll[1]), .collision_clear(collision_clear));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%h expected=0x%h", tag, act, exp);
    end
  endtask

  // Counts enabled edges, the time base for read latency.
  always @(posedge clk)
    if (reset_n && clken && !reset_req) en_cnt++;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_rdv[i]) begin
        if (q[i].size() == 0) begin
          check($sformatf("spurious_valid[%0d]", i), 32'(w_rdv[i]), 32'd0);
        end else begin
          e = q[i].pop_front();
          got[i]++;
          check($sformatf("latency[%0d]", i), en_cnt, e.due);
          check($sformatf("rdata[%0d]", i), w_rdata[i], e.data);
        end
      end else if (q[i].size() > 0 && en_cnt > q[i][0].due) begin
        check($sformatf("missed_valid[%0d]", i), 32'(w_rdv[i]), 32'd1);
        void'(q[i].pop_front());
      end
    end
  end

  function automatic req_t wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    req_t r = '{default: '0};
    r.wr = 1'b1; r.a = a; r.be = be; r.d = d;
    return r;
  endfunction

  function automatic req_t rd(input logic [13:0] a, input logic [31:0] e_old,
                              input logic [31:0] e_new);
    req_t r = '{default: '0};
    r.rd = 1'b1; r.a = a; r.e_old = e_old; r.e_new = e_new;
    return r;
  endfunction

  task automatic push(input int p, input logic [31:0] e_old, input logic [31:0] e_new);
    q[p].push_back('{data: e_old, due: en_cnt + 2});
    q[p+2].push_back('{data: e_new, due: en_cnt + 3});
    pushed[p]++;
    pushed[p+2]++;
  endtask

  task automatic set_idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0;
    s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0;
    s2_writedata = '0;
  endtask

  // Called #1 after an edge; the requests are taken on the following edge.
  task automatic drive(input req_t r1, input req_t r2);
    s1_chipselect = r1.rd | r1.wr; s1_read = r1.rd; s1_write = r1.wr;
    s1_address = r1.a; s1_byteenable = r1.be; s1_writedata = r1.d;
    s2_chipselect = r2.rd | r2.wr; s2_read = r2.rd; s2_write = r2.wr;
    s2_address = r2.a; s2_byteenable = r2.be; s2_writedata = r2.d;
    if (reset_n && clken && !reset_req) begin
      if (r1.rd && !r1.wr) push(0, r1.e_old, r1.e_new);
      if (r2.rd && !r2.wr) push(1, r2.e_old, r2.e_new);
    end
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(NOP, NOP);
  endtask

  task automatic check_coll(input string tag, input logic exp);
    check({tag, "_a"}, 32'(w_coll[0]), 32'(exp));
    check({tag, "_b"}, 32'(w_coll[1]), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; reset_req = 0; clken = 1; collision_clear = 0;
    set_idle();
    for (int i = 0; i < 4; i++) begin pushed[i] = 0; got[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_rdata[%0d]", i), w_rdata[i], 32'd0);
      check($sformatf("reset_valid[%0d]", i), 32'(w_rdv[i]), 32'd0);
    end
    check_coll("reset_coll", 1'b0);
    reset_n = 1;

    // Latency and back-to-back throughput.
    drive(wr(14'h10, 4'hF, 32'hA5A5_1234), NOP);
    repeat (3) drive(NOP, rd(14'h10, 32'hA5A5_1234, 32'hA5A5_1234));
    idle(4);

    // Byte merge collision at the top address.
    drive(wr(14'h3FFF, 4'hF, 32'h0), NOP);
    drive(wr(14'h3FFF, 4'b0011, 32'h1111_1111), wr(14'h3FFF, 4'b0110, 32'h2222_2222));
    check_coll("coll_set", 1'b1);
    drive(rd(14'h3FFF, 32'h0022_1111, 32'h0022_1111), NOP);
    collision_clear = 1;
    drive(NOP, NOP);
    collision_clear = 0;
    check_coll("coll_clear", 1'b0);
    drive(wr(14'h3FFF, 4'b0001, 32'hAAAA_AAAA), wr(14'h3FFF, 4'b0010, 32'hBBBB_BBBB));
    check_coll("coll_disjoint", 1'b0);
    drive(rd(14'h3FFF, 32'h0022_BBAA, 32'h0022_BBAA), rd(14'h3FFF, 32'h0022_BBAA, 32'h0022_BBAA));
    drive(wr(14'h20, 4'hF, 32'h2020_2020), wr(14'h21, 4'hF, 32'h2121_2121));
    check_coll("coll_diff_addr", 1'b0);
    collision_clear = 1;
    drive(wr(14'h40, 4'hF, 32'h4040_0001), wr(14'h40, 4'hF, 32'h4040_0002));
    collision_clear = 0;
    check_coll("coll_set_wins", 1'b1);
    drive(rd(14'h21, 32'h2121_2121, 32'h2121_2121), rd(14'h40, 32'h4040_0001, 32'h4040_0001));
    collision_clear = 1;
    drive(NOP, NOP);
    collision_clear = 0;
    check_coll("coll_clear2", 1'b0);
    idle(3);

    // Read-during-write, cross-port both directions.
    drive(wr(14'h5, 4'hF, 32'hDEAD_BEEF), NOP);
    drive(wr(14'h5, 4'hF, 32'hCAFE_F00D), rd(14'h5, 32'hDEAD_BEEF, 32'hCAFE_F00D));
    drive(rd(14'h5, 32'hCAFE_F00D, 32'h1234_F00D), wr(14'h5, 4'b1100, 32'h1234_5678));
    drive(NOP, rd(14'h5, 32'h1234_F00D, 32'h1234_F00D));
    idle(4);

    // Freeze at the pipeline midpoint; frozen write and read must have no effect.
    drive(NOP, rd(14'h10, 32'hA5A5_1234, 32'hA5A5_1234));
    drive(NOP, NOP);
    clken = 0;
    drive(wr(14'h10, 4'hF, 32'h0), NOP);
    drive(NOP, rd(14'h10, 32'h0, 32'h0));
    clken = 1; reset_req = 1;
    drive(wr(14'h10, 4'hF, 32'h0), NOP);
    reset_req = 0;
    idle(4);
    drive(NOP, rd(14'h10, 32'hA5A5_1234, 32'hA5A5_1234));
    idle(4);

    // Reset while a read is in flight; a write under reset must not land.
    drive(NOP, rd(14'h10, 32'hA5A5_1234, 32'hA5A5_1234));
    reset_n = 0;
    for (int i = 0; i < 4; i++) begin pushed[i] -= q[i].size(); q[i].delete(); end
    drive(wr(14'h10, 4'hF, 32'h0), NOP);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midreset_rdata[%0d]", i), w_rdata[i], 32'd0);
      check($sformatf("midreset_valid[%0d]", i), 32'(w_rdv[i]), 32'd0);
    end
    check_coll("midreset_coll", 1'b0);
    reset_n = 1;
    idle(4);
    drive(NOP, rd(14'h10, 32'hA5A5_1234, 32'hA5A5_1234));
    idle(4);

    // Same-port read+write: write lands, read dropped.
    begin
      req_t rw = wr(14'h7, 4'hF, 32'h7777_7777);
      rw.rd = 1'b1;
      drive(rw, NOP);
    end
    idle(3);
    drive(rd(14'h7, 32'h7777_7777, 32'h7777_7777), NOP);
    idle(5);
    check("hold_rdata_a", w_rdata[0], 32'h7777_7777);
    check("hold_rdata_b", w_rdata[2], 32'h7777_7777);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("pulse_count[%0d]", i), got[i], pushed[i]);
      check($sformatf("queue_left[%0d]", i), 32'(q[i].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
